// File: rtl/faccel_host.sv
// Host-side sequencer for the factorial accelerator register bus: takes one
// request, runs write N / start / poll / read F / stop, and returns n! or an error.
module faccel_host #(
  parameter int unsigned POLL_MAX = 64,
  parameter int unsigned N_MAX    = 12
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  input  logic [3:0]  req_n,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        resp_ready,
  output logic        busy,
  output logic        wel,
  output logic [1:0]  a,
  output logic [3:0]  d,
  input  logic [31:0] rdata
);

  localparam int CW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_N, S_WR_G, S_POLL, S_RD_F, S_CLR_G, S_RESP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_n, w_n_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_err, w_err_nxt;
  logic        r_wel, w_wel_nxt;
  logic [1:0]  r_a, w_a_nxt;
  logic [3:0]  r_d, w_d_nxt;
  logic        r_req_ready, r_resp_valid, r_busy;

  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_n_nxt    = req_n;
          w_data_nxt = '0;
          if (32'(req_n) > N_MAX) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_WR_N;
          end
        end
      end
      S_WR_N: w_state_nxt = S_WR_G;
      S_WR_G: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_POLL;
      end
      S_POLL: begin
        // Only S[0] (done) is architecturally defined; upper S bits are ignored.
        if (rdata[0]) begin
          w_state_nxt = S_RD_F;
        end else if (r_cnt == CW'(POLL_MAX - 1)) begin
          w_err_nxt   = 1'b1;
          w_data_nxt  = '0;
          w_state_nxt = S_CLR_G;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RD_F: begin
        w_data_nxt  = rdata;
        w_state_nxt = S_CLR_G;
      end
      S_CLR_G: w_state_nxt = S_RESP;
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they are registered
    // and line up with the state they belong to.
    w_wel_nxt = 1'b0;
    w_a_nxt   = 2'd0;
    w_d_nxt   = 4'd0;
    unique case (w_state_nxt)
      S_WR_N:  begin w_wel_nxt = 1'b1; w_a_nxt = 2'd0; w_d_nxt = w_n_nxt; end
      S_WR_G:  begin w_wel_nxt = 1'b1; w_a_nxt = 2'd1; w_d_nxt = 4'd1;    end
      S_POLL:  w_a_nxt = 2'd2;
      S_RD_F:  w_a_nxt = 2'd3;
      S_CLR_G: begin w_wel_nxt = 1'b1; w_a_nxt = 2'd1; w_d_nxt = 4'd0;    end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_wel        <= 1'b0;
      r_a          <= 2'd0;
      r_d          <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_n          <= w_n_nxt;
      r_cnt        <= w_cnt_nxt;
      r_data       <= w_data_nxt;
      r_err        <= w_err_nxt;
      r_wel        <= w_wel_nxt;
      r_a          <= w_a_nxt;
      r_d          <= w_d_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign busy       = r_busy;
  assign wel        = r_wel;
  assign a          = r_a;
  assign d          = r_d;

endmodule

// File: tb/tb_faccel_host.sv
// Bench for faccel_host: a behavioural faccel register model drives the main
// instance; a second instance with POLL_MAX=4 sees a done bit stuck at 0.
module tb_faccel_host;

  localparam int POLL_MAX = 64;
  localparam int N_MAX    = 12;
  localparam int TO_POLLS = 4;

  logic        Clk, Rst;
  logic        req_valid, resp_ready;
  logic [3:0]  req_n;
  logic        req_ready, resp_valid, resp_err, busy, wel;
  logic [31:0] resp_data, rdata;
  logic [1:0]  a;
  logic [3:0]  d;

  logic        to_req_valid, to_resp_ready;
  logic [3:0]  to_req_n;
  logic        to_req_ready, to_resp_valid, to_resp_err, to_busy, to_wel;
  logic [31:0] to_resp_data;
  logic [1:0]  to_a;
  logic [3:0]  to_d;

  int n_cmp = 0;
  int n_mis = 0;

  faccel_host #(.POLL_MAX(POLL_MAX), .N_MAX(N_MAX)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready), .busy(busy),
    .wel(wel), .a(a), .d(d), .rdata(rdata)
  );

  faccel_host #(.POLL_MAX(TO_POLLS), .N_MAX(N_MAX)) dut_to (
    .Clk(Clk), .Rst(Rst), .req_valid(to_req_valid), .req_n(to_req_n),
    .req_ready(to_req_ready), .resp_valid(to_resp_valid), .resp_data(to_resp_data),
    .resp_err(to_resp_err), .resp_ready(to_resp_ready), .busy(to_busy),
    .wel(to_wel), .a(to_a), .d(to_d), .rdata(32'h0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] fact(input int n);
    longint r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r[31:0];
  endfunction

  // faccel model: done appears on the poll_target-th poll after G is set.
  int         poll_target = 1;
  logic [3:0] m_n;
  logic       m_g;
  int         m_poll;
  logic [30:0] m_s_hi;

  always @(posedge Clk) begin
    if (wel) begin
      if (a == 2'd0) m_n <= d;
      if (a == 2'd1) begin
        m_g <= d[0];
        if (d[0]) begin
          m_poll <= 0;
          m_s_hi <= 31'($urandom);
        end
      end
    end else if (a == 2'd2) begin
      m_poll <= m_poll + 1;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (a)
      2'd0: rdata = {28'h0, m_n};
      2'd1: rdata = {31'h0, m_g};
      2'd2: rdata = {m_s_hi, (m_g && (m_poll >= poll_target - 1))};
      2'd3: rdata = fact(int'(m_n));
      default: rdata = 32'h0;
    endcase
  end

  // Bus monitors, sampled mid-cycle.
  logic [5:0] m_wr[$];
  int         m_polls, m_rds;
  logic [5:0] to_wr[$];
  int         to_polls;

  always @(negedge Clk) begin
    if (wel) m_wr.push_back({a, d});
    if (!wel && a == 2'd2) m_polls++;
    if (!wel && a == 2'd3) m_rds++;
    if (to_wel) to_wr.push_back({to_a, to_d});
    if (!to_wel && to_a == 2'd2) to_polls++;
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] n, input int p, input int hold,
                         input bit pulse_req, input string tag);
    bit          rej, tmo, seen, bad_hs, unstable;
    logic [31:0] exp_data, d0;
    logic        exp_err;
    int          exp_lat, exp_polls, exp_rds, lat;
    logic [5:0]  exp_wr[$];

    rej = (int'(n) > N_MAX);
    tmo = !rej && (p > POLL_MAX);
    exp_err   = rej || tmo;
    exp_data  = exp_err ? 32'h0 : fact(int'(n));
    exp_lat   = rej ? 0 : (tmo ? POLL_MAX + 3 : p + 4);
    exp_polls = rej ? 0 : (tmo ? POLL_MAX : p);
    exp_rds   = (rej || tmo) ? 0 : 1;
    if (!rej) begin
      exp_wr.push_back({2'd0, n});
      exp_wr.push_back({2'd1, 4'd1});
      exp_wr.push_back({2'd1, 4'd0});
    end

    poll_target = p;
    step();
    m_wr.delete();
    m_polls = 0;
    m_rds   = 0;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    end

    req_valid = 1'b1;
    req_n     = n;
    seen = 0; bad_hs = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      req_valid = 1'b0;
      if (resp_valid === 1'b1) begin
        seen = 1;
        lat  = i;
        break;
      end
      if (req_ready !== 1'b0 || busy !== 1'b1) bad_hs = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL %s resp_wait: no resp_valid within 200 cycles", tag);
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_mis++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    n_cmp++;
    if (resp_data !== exp_data || resp_err !== exp_err) begin
      n_mis++;
      $display("FAIL %s resp: got data=%0d err=%b want data=%0d err=%b",
               tag, resp_data, resp_err, exp_data, exp_err);
    end
    n_cmp++;
    if (bad_hs) begin
      n_mis++;
      $display("FAIL %s busy_flags: req_ready/busy wrong while busy, want 0/1", tag);
    end

    d0 = resp_data;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      if (pulse_req) begin
        req_valid = (i % 3 == 1);
        req_n     = 4'($urandom_range(0, 12));
      end
      step();
      if (resp_valid !== 1'b1 || resp_data !== d0 || req_ready !== 1'b0 || busy !== 1'b1)
        unstable = 1;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (unstable) begin
      n_mis++;
      $display("FAIL %s hold: response not stable over %0d stalled cycles", tag, hold);
    end

    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s release: got valid=%b ready=%b busy=%b want 0 1 0",
               tag, resp_valid, req_ready, busy);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || m_wr.size() != exp_wr.size()) begin
      n_mis++;
      $display("FAIL %s bus_writes: got %0d writes busy=%b want %0d writes busy=0",
               tag, m_wr.size(), busy, exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        n_cmp++;
        if (m_wr[i] !== exp_wr[i]) begin
          n_mis++;
          $display("FAIL %s write%0d: got a=%0d d=%0d want a=%0d d=%0d", tag, i,
                   m_wr[i][5:4], m_wr[i][3:0], exp_wr[i][5:4], exp_wr[i][3:0]);
        end
      end
    end
    n_cmp++;
    if (m_polls != exp_polls || m_rds != exp_rds) begin
      n_mis++;
      $display("FAIL %s poll_read: got polls=%0d reads=%0d want %0d %0d",
               tag, m_polls, m_rds, exp_polls, exp_rds);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [44:0] got;
    got = {wel, a, d, req_ready, resp_valid, resp_err, busy, resp_data};
    n_cmp++;
    if (got !== {1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_mis++;
      $display("FAIL %s reset_values: got wel=%b a=%0d d=%0d rdy=%b vld=%b err=%b busy=%b data=%0d want 0 0 0 1 0 0 0 0",
               tag, wel, a, d, req_ready, resp_valid, resp_err, busy, resp_data);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    req_valid = 1'b0; req_n = 4'd0; resp_ready = 1'b0;
    to_req_valid = 1'b0; to_req_n = 4'd0; to_resp_ready = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset_hold");
    Rst = 1'b1;
    repeat (2) step();
    check_reset_outputs("reset_release");
  endtask

  task automatic test_nominal();
    run_txn(4'd5, $urandom_range(1, 8), 0, 0, "nominal_n5");
  endtask

  task automatic test_boundaries();
    run_txn(4'd0,  $urandom_range(1, 6), 0, 0, "n0");
    run_txn(4'd1,  $urandom_range(1, 6), 0, 0, "n1");
    run_txn(4'd12, $urandom_range(1, 6), 0, 0, "n12");
    run_txn(4'd7,  1,            0, 0, "first_poll_done");
    run_txn(4'd9,  POLL_MAX,     0, 0, "done_on_last_poll");
    run_txn(4'd4,  POLL_MAX + 1, 0, 0, "main_timeout");
  endtask

  task automatic test_reject();
    run_txn(4'd13, 1, 0, 0, "reject_n13");
    run_txn(4'($urandom_range(13, 15)), 1, 1, 0, "reject_rand");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++)
      run_txn(4'($urandom_range(0, 15)), $urandom_range(1, 10),
              $urandom_range(0, 3), 0, "random");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      run_txn(4'($urandom_range(2, 12)), $urandom_range(1, 3), 0, 0, "back_to_back");
  endtask

  task automatic test_backpressure();
    run_txn(4'd6, $urandom_range(1, 5), 10, 1, "backpressure");
  endtask

  task automatic test_timeout();
    bit seen;
    int lat;
    step();
    to_wr.delete();
    to_polls = 0;
    to_req_valid = 1'b1;
    to_req_n = 4'($urandom_range(0, 12));
    seen = 0; lat = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      to_req_valid = 1'b0;
      if (to_resp_valid === 1'b1) begin
        seen = 1;
        lat  = i;
        break;
      end
    end
    n_cmp++;
    if (!seen || lat != TO_POLLS + 3) begin
      n_mis++;
      $display("FAIL timeout latency: got %0d (seen=%b) want %0d", lat, seen, TO_POLLS + 3);
    end
    n_cmp++;
    if (to_resp_err !== 1'b1 || to_resp_data !== 32'h0) begin
      n_mis++;
      $display("FAIL timeout resp: got err=%b data=%0d want 1 0", to_resp_err, to_resp_data);
    end
    to_resp_ready = 1'b1;
    step();
    to_resp_ready = 1'b0;
    n_cmp++;
    if (to_busy !== 1'b0 || to_polls != TO_POLLS) begin
      n_mis++;
      $display("FAIL timeout polls: got polls=%0d busy=%b want %0d 0", to_polls, to_busy, TO_POLLS);
    end
    n_cmp++;
    if (to_wr.size() != 3 || to_wr[to_wr.size() - 1] !== {2'd1, 4'd0}) begin
      n_mis++;
      $display("FAIL timeout clr_g: got %0d writes want 3 ending a=1 d=0", to_wr.size());
    end
  endtask

  task automatic test_reset_mid_poll();
    poll_target = 40;
    step();
    req_valid = 1'b1;
    req_n = 4'd7;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    n_cmp++;
    if (a !== 2'd2 || wel !== 1'b0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL mid_poll state: got a=%0d wel=%b busy=%b want 2 0 1", a, wel, busy);
    end
    #2;
    Rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_wr.delete();
    repeat (3) step();
    Rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (m_wr.size() != 0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_abort: got %0d writes busy=%b want 0 0", m_wr.size(), busy);
    end
    run_txn(4'd3, $urandom_range(1, 6), 0, 0, "after_reset_n3");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_reject();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_poll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
